iob_mul_shiftadd: RTL and testbench
===================================

IOB_MUL_SHIFTADD -- requirements
Module: iob_mul_shiftadd

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width in bits (DATA_W >= 2).
REQ-002 SHALL have port clk_i, input, 1, clock; one clock domain, all state on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port cke_i, input, 1, clock enable; when low, all state holds.
REQ-005 SHALL have port start_i, input, 1, operation request, sampled only in IDLE.
REQ-006 SHALL have port done_o, output, 1, high when idle or result valid; low while computing.
REQ-007 SHALL have port multiplicand_i, input, DATA_W, first operand.
REQ-008 SHALL have port multiplier_i, input, DATA_W, second operand.
REQ-009 SHALL have port product_o, output, 2*DATA_W, registered result.

Function
REQ-010 SHALL implement a sequential shift-and-add multiplier with states IDLE, RUN (counter 1..DATA_W), FIX (signed builds only) and DONE.
REQ-011 In IDLE with start_i=1 and cke_i=1, SHALL register multiplicand_i, load multiplier_i into product low half, clear product high half and a carry bit, and enter RUN.
REQ-012 In IDLE with start_i=0, SHALL stay in IDLE and hold product_o.
REQ-013 Each RUN cycle: if product bit 0 is 1, SHALL add multiplicand to the high half in DATA_W+1 bits; then SHALL shift {carry, high, low} right one bit.
REQ-014 After DATA_W RUN cycles, SHALL enter DONE (or FIX when enabled); product_o then equals the full 2*DATA_W product with no truncation.
REQ-015 DONE SHALL last exactly one cycle, SHALL ignore start_i, and SHALL then return to IDLE.
REQ-016 done_o SHALL be 0 in RUN and FIX and 1 in IDLE and DONE.
REQ-017 Latency: done_o SHALL be low for exactly DATA_W cycles after the start edge (DATA_W+1 with signed), and the result SHALL be valid on the first cycle done_o returns high.
REQ-018 start_i asserted in RUN, FIX or DONE SHALL be ignored, with no queuing.
REQ-019 Operand inputs SHALL be sampled only at the accepting edge; later changes SHALL NOT affect the result.
REQ-020 product_o SHALL hold its value from completion until the next accepted start.
REQ-021 The internal cycle counter SHALL be sized to reach DATA_W+2 without wrap.

Reset
REQ-022 rst_i=1 at a rising edge SHALL force IDLE, clear the counter, operand register, carry and product_o to 0, and set done_o to 1, regardless of cke_i.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no partial result retained.
REQ-024 The first start_i after reset release SHALL be accepted normally.

Configuration
REQ-025 Macro IOB_MUL_SHIFTADD_SIGNED_EN SHALL select the signed-arithmetic feature.
REQ-026 With the macro defined: operands SHALL be two's complement; at load, each operand SHALL be replaced by its magnitude and the XOR of the sign bits stored; FIX SHALL negate the 2*DATA_W product if that XOR is 1; latency becomes DATA_W+1.
REQ-027 Without the macro: operands SHALL be unsigned, FIX SHALL be absent, and no sign logic SHALL be synthesized.

Verification (DATA_W=8)
REQ-028 Unsigned: 13 x 11 -> product_o=0x008F; done_o low for 8 cycles.
REQ-029 Unsigned extremes: 0xFF x 0xFF -> 0xFE01; 0x00 x 0xA5 -> 0x0000.
REQ-030 Start held high through an operation; operands changed at cycle 3 -> result uses the original operands, and exactly one extra operation starts, from IDLE after DONE.
REQ-031 Reset asserted at RUN cycle 4 -> next cycle done_o=1 and product_o=0x0000; a following 7 x 9 -> 0x003F.
REQ-032 Signed (macro defined): -3 x 5 -> 0xFFF1; -128 x -128 -> 0x4000; 127 x -1 -> 0xFF81; done_o low for 9 cycles.
REQ-033 cke_i held low for 5 cycles mid-RUN -> completion delayed by exactly 5 cycles with the result unchanged.

Source files
------------

// File: rtl/iob_mul_shiftadd.sv
// ============================================================================
// Module  : iob_mul_shiftadd
// Brief   : Sequential shift-and-add multiplier, one product bit per cycle.
//           Define IOB_MUL_SHIFTADD_SIGNED_EN for two's-complement operands.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_mul_shiftadd #(
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cke_i,
    input  logic                  start_i,
    output logic                  done_o,
    input  logic [DATA_W-1:0]     multiplicand_i,
    input  logic [DATA_W-1:0]     multiplier_i,
    output logic [2*DATA_W-1:0]   product_o
);

    localparam int c_cnt_w = $clog2(DATA_W + 3);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [DATA_W-1:0]      r_mcand;
    logic                   r_carry;
    logic [2*DATA_W-1:0]    r_product;

    logic [DATA_W-1:0]      w_load_mcand;
    logic [DATA_W-1:0]      w_load_mplier;
    logic [DATA_W-1:0]      w_addend;
    logic [DATA_W:0]        w_sum;
    logic [2*DATA_W:0]      w_shifted;

`ifdef IOB_MUL_SHIFTADD_SIGNED_EN
    logic                   r_sign;

    // Magnitudes are taken at load; -2^(W-1) maps to 2^(W-1), which still fits unsigned.
    assign w_load_mcand  = multiplicand_i[DATA_W-1] ? -multiplicand_i : multiplicand_i;
    assign w_load_mplier = multiplier_i[DATA_W-1]   ? -multiplier_i   : multiplier_i;
`else
    assign w_load_mcand  = multiplicand_i;
    assign w_load_mplier = multiplier_i;
`endif

    assign w_addend  = r_product[0] ? r_mcand : '0;
    assign w_sum     = {r_carry, r_product[2*DATA_W-1:DATA_W]} + {1'b0, w_addend};
    assign w_shifted = {1'b0, w_sum, r_product[DATA_W-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == c_cnt_last) begin
`ifdef IOB_MUL_SHIFTADD_SIGNED_EN
                    w_state_nxt = S_FIX;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef IOB_MUL_SHIFTADD_SIGNED_EN
            S_FIX: begin
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_carry   <= 1'b0;
            r_product <= '0;
`ifdef IOB_MUL_SHIFTADD_SIGNED_EN
            r_sign    <= 1'b0;
`endif
        end else if (cke_i) begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_cnt     <= c_cnt_w'(1);
                        r_mcand   <= w_load_mcand;
                        r_carry   <= 1'b0;
                        r_product <= {{DATA_W{1'b0}}, w_load_mplier};
`ifdef IOB_MUL_SHIFTADD_SIGNED_EN
                        r_sign    <= multiplicand_i[DATA_W-1] ^ multiplier_i[DATA_W-1];
`endif
                    end
                end
                S_RUN: begin
                    // Carry out of the add lands in the high half's MSB after the shift.
                    r_carry   <= w_shifted[2*DATA_W];
                    r_product <= w_shifted[2*DATA_W-1:0];
                    if (r_cnt != c_cnt_last) begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
`ifdef IOB_MUL_SHIFTADD_SIGNED_EN
                S_FIX: begin
                    if (r_sign) begin
                        r_product <= -r_product;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign done_o    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign product_o = r_product;

endmodule

`default_nettype wire

// File: tb/tb_iob_mul_shiftadd.sv
// ============================================================================
// Module  : tb_iob_mul_shiftadd
// Brief   : Self-checking bench for iob_mul_shiftadd at DATA_W=8.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iob_mul_shiftadd;

    localparam int W = 8;
`ifdef IOB_MUL_SHIFTADD_SIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic           cke   = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a     = '0;
    logic [W-1:0]   b     = '0;
    logic           done;
    logic [2*W-1:0] prod;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iob_mul_shiftadd #(.DATA_W(W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cke_i          (cke),
        .start_i        (start),
        .done_o         (done),
        .multiplicand_i (a),
        .multiplier_i   (b),
        .product_o      (prod)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef IOB_MUL_SHIFTADD_SIGNED_EN
        int sx;
        int sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        return 16'(sx * sy);
`else
        return 16'({8'd0, x} * {8'd0, y});
`endif
    endfunction

    // Reference: an accepted start yields LAT busy cycles, then one cycle in which
    // start is ignored; the product is the arithmetic result from the accepting edge.
    int             m_busy    = 0;
    bit             m_block   = 1'b0;
    bit             m_live    = 1'b0;
    logic [2*W-1:0] m_result  = '0;
    logic [2*W-1:0] m_pending = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy   = 0;
            m_block  = 1'b0;
            m_result = '0;
            m_live   = 1'b1;
        end else if (cke) begin
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_result = m_pending;
                    m_block  = 1'b1;
                end
            end else if (m_block) begin
                m_block = 1'b0;
            end else if (start) begin
                m_busy    = LAT;
                m_pending = model_prod(a, b);
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("done_o", 32'(done), 32'(m_busy == 0));
            if (m_busy == 0) begin
                check("product_o", 32'(prod), 32'(m_result));
            end
        end
    end

    // Called on a falling edge in IDLE; leaves the DUT in IDLE on a falling edge.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [2*W-1:0] exp, input string name);
        int n;
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = ~x;
        b     = y ^ 8'h5A;
        n     = 0;
        while (!done && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, "_latency"}, 32'(n), 32'(LAT));
        check(name, 32'(prod), 32'(exp));
        @(negedge clk);
        check({name, "_hold"}, 32'(prod), 32'(exp));
    endtask

    initial begin
        int n;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_done", 32'(done), 32'd1);
        check("reset_product", 32'(prod), 32'h0);

        check("model_pin_13x11", 32'(model_prod(8'd13, 8'd11)), 32'h008F);
`ifdef IOB_MUL_SHIFTADD_SIGNED_EN
        check("model_pin_m3x5", 32'(model_prod(8'hFD, 8'd5)), 32'hFFF1);
        check("model_pin_m128sq", 32'(model_prod(8'h80, 8'h80)), 32'h4000);
`else
        check("model_pin_ffsq", 32'(model_prod(8'hFF, 8'hFF)), 32'hFE01);
`endif

        rst = 1'b0;
        run_op(8'd13, 8'd11, 16'h008F, "mul_13x11");
`ifdef IOB_MUL_SHIFTADD_SIGNED_EN
        run_op(8'hFD, 8'd5,  16'hFFF1, "mul_m3x5");
        run_op(8'h80, 8'h80, 16'h4000, "mul_m128xm128");
        run_op(8'h7F, 8'hFF, 16'hFF81, "mul_127xm1");
        run_op(8'h05, 8'hFD, 16'hFFF1, "mul_5xm3");
`else
        run_op(8'hFF, 8'hFF, 16'hFE01, "mul_ffxff");
        run_op(8'h00, 8'hA5, 16'h0000, "mul_00xa5");
        run_op(8'hA5, 8'h01, 16'h00A5, "mul_a5x01");
`endif

        // start held high across an operation, operands changed mid-run
        start = 1'b1;
        a     = 8'd3;
        b     = 8'd5;
        @(negedge clk);
        n = 0;
        while (!done && n < 100) begin
            n++;
            if (n == 3) begin
                a = 8'd10;
                b = 8'd12;
            end
            @(negedge clk);
        end
        check("held_latency", 32'(n), 32'(LAT));
        check("held_first", 32'(prod), 32'h000F);
        @(negedge clk);
        check("held_idle_gap", 32'(done), 32'd1);
        @(negedge clk);
        check("held_restart", 32'(done), 32'd0);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("held_second", 32'(prod), 32'h0078);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("held_no_queue", 32'(done), 32'd1);
        end

        // reset in the middle of a run
        start = 1'b1;
        a     = 8'd13;
        b     = 8'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_done", 32'(done), 32'd1);
        check("abort_product", 32'(prod), 32'h0);
        rst = 1'b0;
        run_op(8'd7, 8'd9, 16'h003F, "mul_7x9_after_abort");

        // clock enable dropped for five cycles mid-run
        start = 1'b1;
        a     = 8'd25;
        b     = 8'd9;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            n++;
            if (n == 3) cke = 1'b0;
            if (n == 8) cke = 1'b1;
            @(negedge clk);
        end
        check("cke_latency", 32'(n), 32'(LAT + 5));
        check("cke_product", 32'(prod), 32'h00E1);
        @(negedge clk);

        // start ignored in IDLE while clock enable is low
        cke   = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("cke_idle_hold", 32'(done), 32'd1);
        end
        start = 1'b0;
        cke   = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
